// File: rtl/vga_box_gen_pkg.sv
// Shared constants and types for the bouncing-box VGA pattern generator.
package vga_box_gen_pkg;

    // Visible screen geometry
    localparam int unsigned HD           = 640;
    localparam int unsigned VD           = 480;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

    // 4:4:4 colour
    localparam int unsigned COLOR_W = 12;
    localparam logic [COLOR_W-1:0] BOX_RGB_DEF    = 12'hF00;
    localparam logic [COLOR_W-1:0] BG_RGB_DEF     = 12'h000;
    localparam logic [COLOR_W-1:0] BORDER_RGB_DEF = 12'hFFF;

    // Axis direction: Inc = right/down, Dec = left/up
    typedef enum logic {
        AxisInc,
        AxisDec
    } axis_dir_e;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of box motion: position register plus a two-state bounce FSM that
// advances only on the frame tick and clamps to the screen edge on a bounce.
module vga_bounce_axis
    import vga_box_gen_pkg::*;
#(
    parameter int unsigned LIMIT = 639,
    parameter int unsigned SIZE  = 32,
    parameter int unsigned SPEED = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    output logic [9:0] pos
);

    localparam logic [10:0] LIM11   = 11'(LIMIT);
    localparam logic [10:0] SIZE11  = 11'(SIZE);
    localparam logic [10:0] SPEED11 = 11'(SPEED);

    axis_dir_e   r_dir;
    axis_dir_e   w_dir_d;
    logic [9:0]  r_pos;
    logic [9:0]  w_pos_d;
    logic [10:0] w_pos_ext;

    assign w_pos_ext = {1'b0, r_pos};
    assign pos       = r_pos;

    // State and position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= AxisInc;
            r_pos <= '0;
        end else begin
            r_dir <= w_dir_d;
            r_pos <= w_pos_d;
        end
    end

    // Next-state: move by SPEED, or clamp to the edge and reverse
    always_comb begin
        w_dir_d = r_dir;
        w_pos_d = r_pos;
        if (tick) begin
            unique case (r_dir)
                AxisInc: begin
                    if (w_pos_ext + SIZE11 + SPEED11 > LIM11) begin
                        w_pos_d = 10'(LIM11 + 11'd1 - SIZE11);
                        w_dir_d = AxisDec;
                    end else begin
                        w_pos_d = 10'(w_pos_ext + SPEED11);
                    end
                end
                AxisDec: begin
                    if (w_pos_ext < SPEED11) begin
                        w_pos_d = '0;
                        w_dir_d = AxisInc;
                    end else begin
                        w_pos_d = 10'(w_pos_ext - SPEED11);
                    end
                end
                default: begin
                    w_pos_d = r_pos;
                    w_dir_d = AxisInc;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_box_gen.sv
// Bouncing-box VGA pattern generator. Registers rgb and syncs with 1 clk
// latency; the box moves once per frame, during vertical blanking.
// Optional macro VGA_BOX_BORDER_EN draws a white 1-pixel screen border.
module vga_box_gen
    import vga_box_gen_pkg::*;
#(
    parameter int unsigned        BOX_SIZE = 32,
    parameter int unsigned        SPEED    = 2,
    parameter logic [COLOR_W-1:0] BOX_RGB  = BOX_RGB_DEF,
    parameter logic [COLOR_W-1:0] BG_RGB   = BG_RGB_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hSync_in,
    input  logic               vSync_in,
    input  logic               v_ON,
    input  logic [9:0]         p_x,
    input  logic [9:0]         p_y,
    output logic               hSync,
    output logic               vSync,
    output logic [COLOR_W-1:0] rgb
);

    localparam logic [10:0] BOX11 = 11'(BOX_SIZE);

    logic               r_frame_cond;
    logic               w_frame_cond;
    logic               w_tick;
    logic [9:0]         w_box_x;
    logic [9:0]         w_box_y;
    logic               w_inside;
    logic [COLOR_W-1:0] w_rgb_d;

    // Inputs are held for several clocks per pixel, so only the rising edge ticks
    assign w_frame_cond = (p_y == 10'(VD)) && (p_x == 10'd0);
    assign w_tick       = w_frame_cond & ~r_frame_cond;

    // Tick edge-detect register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cond <= 1'b0;
        end else begin
            r_frame_cond <= w_frame_cond;
        end
    end

    vga_bounce_axis #(
        .LIMIT (SCREEN_X_MAX),
        .SIZE  (BOX_SIZE),
        .SPEED (SPEED)
    ) u_axis_x (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .pos  (w_box_x)
    );

    vga_bounce_axis #(
        .LIMIT (SCREEN_Y_MAX),
        .SIZE  (BOX_SIZE),
        .SPEED (SPEED)
    ) u_axis_y (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .pos  (w_box_y)
    );

    // 11-bit compares so box_pos+BOX_SIZE cannot wrap
    assign w_inside = ({1'b0, p_x} >= {1'b0, w_box_x}) &&
                      ({1'b0, p_x} <  {1'b0, w_box_x} + BOX11) &&
                      ({1'b0, p_y} >= {1'b0, w_box_y}) &&
                      ({1'b0, p_y} <  {1'b0, w_box_y} + BOX11);

    // Pixel colour selection
    always_comb begin
        w_rgb_d = '0;
        if (v_ON) begin
`ifdef VGA_BOX_BORDER_EN
            if (p_x == 10'd0 || p_x == 10'(SCREEN_X_MAX) ||
                p_y == 10'd0 || p_y == 10'(SCREEN_Y_MAX)) begin
                w_rgb_d = BORDER_RGB_DEF;
            end else if (w_inside) begin
                w_rgb_d = BOX_RGB;
            end else begin
                w_rgb_d = BG_RGB;
            end
`else
            w_rgb_d = w_inside ? BOX_RGB : BG_RGB;
`endif
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= '0;
            hSync <= 1'b0;
            vSync <= 1'b0;
        end else begin
            rgb   <= w_rgb_d;
            hSync <= hSync_in;
            vSync <= vSync_in;
        end
    end

endmodule

// File: tb/tb_vga_box_gen.sv
// Directed self-checking bench for vga_box_gen (default parameters).
module tb_vga_box_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        hSync_in;
    logic        vSync_in;
    logic        v_ON;
    logic [9:0]  p_x;
    logic [9:0]  p_y;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb;

    int n_total = 0;
    int n_pass  = 0;

    vga_box_gen u_dut (
        .clk      (clk),
        .rst      (rst),
        .hSync_in (hSync_in),
        .vSync_in (vSync_in),
        .v_ON     (v_ON),
        .p_x      (p_x),
        .p_y      (p_y),
        .hSync    (hSync),
        .vSync    (vSync),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame tick: condition high for one clock, then low
    task automatic tick();
        p_x = 10'd0;
        p_y = 10'd480;
        cyc(1);
        p_y = 10'd0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst      = 1'b1;
        hSync_in = 1'b1;
        vSync_in = 1'b1;
        v_ON     = 1'b0;
        p_x      = 10'd0;
        p_y      = 10'd0;
        #1;
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_hsync", {11'd0, hSync}, 12'd0);
        chk("reset_vsync", {11'd0, vSync}, 12'd0);
        cyc(2);
        rst = 1'b0;

        // Default box at (0,0), pixel inside
        v_ON = 1'b1;
        p_x  = 10'd5;
        p_y  = 10'd5;
        cyc(1);
        chk("box_pixel", rgb, 12'hF00);
        chk("hsync_follow", {11'd0, hSync}, 12'd1);

        // v_ON low blanks even inside the box; hSync delayed exactly 1 clk
        v_ON     = 1'b0;
        p_x      = 10'd10;
        p_y      = 10'd10;
        hSync_in = 1'b0;
        #1;
        chk("hsync_not_yet", {11'd0, hSync}, 12'd1);
        cyc(1);
        chk("blank_rgb", rgb, 12'h000);
        chk("hsync_delay", {11'd0, hSync}, 12'd0);
        hSync_in = 1'b1;
        v_ON     = 1'b1;

        // Frame condition held 4 clk gives a single update
        p_x = 10'd0;
        p_y = 10'd480;
        cyc(4);
        p_y = 10'd0;
        cyc(1);
        chk("hold4_x", {2'd0, u_dut.w_box_x}, 12'd2);
        chk("hold4_y", {2'd0, u_dut.w_box_y}, 12'd2);

        // 99 more ticks -> (200,200)
        ticks(99);
        chk("t100_x", {2'd0, u_dut.w_box_x}, 12'd200);
        chk("t100_y", {2'd0, u_dut.w_box_y}, 12'd200);
        p_x = 10'd210;
        p_y = 10'd230;
        cyc(1);
        chk("moved_inside", rgb, 12'hF00);
        p_x = 10'd5;
        p_y = 10'd5;
        cyc(1);
        chk("moved_bg", rgb, 12'h000);
        p_x = 10'd232;
        p_y = 10'd210;
        cyc(1);
        chk("right_edge_excl", rgb, 12'h000);

        // Up to 303 ticks: x=606 heading right; y bounced at 448 and is at 290
        ticks(203);
        chk("t303_x", {2'd0, u_dut.w_box_x}, 12'd606);
        chk("t303_y", {2'd0, u_dut.w_box_y}, 12'd290);
        tick();
        chk("bounce_x_clamp", {2'd0, u_dut.w_box_x}, 12'd608);
        tick();
        chk("bounce_x_back", {2'd0, u_dut.w_box_x}, 12'd606);
        chk("t305_y", {2'd0, u_dut.w_box_y}, 12'd286);

        // Async reset mid-frame, away from any clock edge
        p_x = 10'd620;
        p_y = 10'd300;
        cyc(1);
        chk("pre_rst_rgb", rgb, 12'hF00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rgb", rgb, 12'h000);
        chk("async_hsync", {11'd0, hSync}, 12'd0);
        chk("async_vsync", {11'd0, vSync}, 12'd0);
        chk("async_box_x", {2'd0, u_dut.w_box_x}, 12'd0);
        chk("async_box_y", {2'd0, u_dut.w_box_y}, 12'd0);
        cyc(1);
        rst = 1'b0;
        p_x = 10'd0;
        p_y = 10'd10;
        cyc(1);
`ifdef VGA_BOX_BORDER_EN
        chk("border_pixel", rgb, 12'hFFF);
`else
        chk("border_pixel", rgb, 12'hF00);
`endif
        tick();
        chk("post_rst_x", {2'd0, u_dut.w_box_x}, 12'd2);
        chk("post_rst_y", {2'd0, u_dut.w_box_y}, 12'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_box_gen.md
VGA_BOX_GEN -- requirements
Module: vga_box_gen

Interface
REQ-001 Parameter BOX_SIZE, default 32: side length of the square in pixels (2..240).
REQ-002 Parameter SPEED, default 2: pixels moved per frame on each axis (1..15).
REQ-003 Parameter BOX_RGB, default 12'hF00: box colour, 4:4:4.
REQ-004 Parameter BG_RGB, default 12'h000: background colour, 4:4:4.
REQ-005 clk  in  1: system clock, the same clock that drives the sync generator.
REQ-006 rst  in  1: reset, asynchronous and active-high.
REQ-007 hSync_in / vSync_in  in  1 each: active-low syncs from the sync generator.
REQ-008 v_ON  in  1: video-active flag.
REQ-009 p_x / p_y  in  10 each: current pixel column and row.
REQ-010 hSync / vSync  out  1 each: syncs delayed to align with rgb.
REQ-011 rgb  out  12: pixel colour, {R[3:0],G[3:0],B[3:0]}.

Function
REQ-012 All outputs are registered, with 1 clk latency from the inputs.
  - hSync = hSync_in and vSync = vSync_in, each delayed 1 clk.
REQ-013 Pixel is inside the box when box_x <= p_x < box_x+BOX_SIZE and box_y <= p_y < box_y+BOX_SIZE.
  - Comparisons are done in 11-bit arithmetic; there is no wrap.
REQ-014 Next rgb value:
  - v_ON=0 gives 12'h000.
  - Otherwise inside the box gives BOX_RGB, else BG_RGB.
REQ-015 Frame tick is a 1-clk pulse on the 0->1 edge of the registered condition (p_y==480 && p_x==0).
  - There is exactly one tick per frame, even though the inputs are held for 4 clk per pixel.
REQ-016 Horizontal motion state machine has states RIGHT and LEFT and updates only on a tick.
  - RIGHT: if box_x+BOX_SIZE+SPEED > 639, then box_x <= 640-BOX_SIZE and state <= LEFT; else box_x <= box_x+SPEED.
  - LEFT: if box_x < SPEED, then box_x <= 0 and state <= RIGHT; else box_x <= box_x-SPEED.
REQ-017 Vertical motion state machine has states DOWN and UP, with the same rule as REQ-016 using the limit 479/480 and box_y.
REQ-018 Position updates happen only on a tick.
  - box_x/box_y change only during vertical blanking, so the box never tears mid-frame.
REQ-019 A bounce and a move in the same tick are resolved as a clamp to the edge.
  - The box never leaves 0..639 x 0..479.

Reset
REQ-020 On rst:
  - rgb=12'h000, hSync=0, vSync=0.
  - box_x=0, box_y=0, horizontal state RIGHT, vertical state DOWN.
  - tick-edge register=0.
REQ-021 Reset asserted mid-frame takes effect immediately, without waiting for a clock.
  - After release, the first tick occurs at the next p_y==480, p_x==0.

Configuration
REQ-022 Macro VGA_BOX_BORDER_EN.
  - When defined: pixels with p_x==0, p_x==639, p_y==0 or p_y==479 (with v_ON=1) output 12'hFFF.
  - The border has priority over the box.
  - When undefined: no border logic is built, and REQ-014 applies unchanged.

Structure
REQ-023 A shared package/include holds the timing constants, the colour width, and the BOX/BG default colours:
  - HD=640, VD=480, SCREEN_X_MAX=639, SCREEN_Y_MAX=479.
  - Colour width = 12.
REQ-024 One sub-module, vga_bounce_axis, is instantiated twice, once for x and once for y.
  - Parameters: limit, size, speed.
  - Ports: clk, rst, tick, pos[9:0].
  - Implements the 2-state machine of REQ-016.

Verification
REQ-025 Reset, then one clk with v_ON=1, p_x=5, p_y=5 -> rgb=12'hF00 (default box at 0,0).
REQ-026 Frame tick with box_x=606, RIGHT, SPEED=2 -> box_x=608, state LEFT; next tick -> box_x=606.
REQ-027 p_y==480 && p_x==0 held for 4 clk -> exactly one position update (box_x 0->2, box_y 0->2).
REQ-028 v_ON=0, p_x=10, p_y=10 inside the box -> rgb=12'h000 one clk later.
  - hSync_in toggle appears on hSync exactly 1 clk later.
REQ-029 Assert rst asynchronously mid-frame with box at (300,200) -> rgb, hSync and vSync go to 0 before the next clk edge, and box returns to (0,0).
REQ-030 With VGA_BOX_BORDER_EN, box at (0,0), p_x=0, p_y=10, v_ON=1 -> rgb=12'hFFF; without the macro -> 12'hF00.
